// File: rtl/lstm_gate_scheduler.sv
// Time-multiplexes one shared multiply-add unit across NUM_GATES LSTM gate pre-activations.
// Optional macro LSTM_MAC_PIPE_EN: shared unit has one output register; a DRAIN state captures the last gate.
module lstm_gate_scheduler #(
   parameter int DATA_WIDTH  = 16,
   parameter int FRACT_WIDTH = 8,
   parameter int NUM_GATES   = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_WIDTH-1:0]           x,
   input  logic [DATA_WIDTH-1:0]           h_in,
   input  logic [NUM_GATES*DATA_WIDTH-1:0] w0_all,
   input  logic [NUM_GATES*DATA_WIDTH-1:0] w1_all,
   input  logic [NUM_GATES*DATA_WIDTH-1:0] b_all,
   output logic                            mac_en,
   output logic [DATA_WIDTH-1:0]           mac_x,
   output logic [DATA_WIDTH-1:0]           mac_h,
   output logic [DATA_WIDTH-1:0]           mac_w0,
   output logic [DATA_WIDTH-1:0]           mac_w1,
   output logic [DATA_WIDTH-1:0]           mac_b,
   input  logic [DATA_WIDTH-1:0]           mac_out,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_GATES*DATA_WIDTH-1:0] gates_out,
   output logic                            busy
);

   localparam int CNT_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_GATES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   if (FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract
      $error("FRACT_WIDTH must be smaller than DATA_WIDTH");
   end

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] x_q, x_d, h_q, h_d;
   logic [DATA_WIDTH-1:0] gates_q [NUM_GATES];
   logic [DATA_WIDTH-1:0] gates_d [NUM_GATES];
   logic [DATA_WIDTH-1:0] w0_arr  [NUM_GATES];
   logic [DATA_WIDTH-1:0] w1_arr  [NUM_GATES];
   logic [DATA_WIDTH-1:0] b_arr   [NUM_GATES];
   logic                  wr_en_s;
   logic [CNT_W-1:0]      wr_idx_s;

   for (genvar g = 0; g < NUM_GATES; g++) begin : g_slice
      assign w0_arr[g] = w0_all[g*DATA_WIDTH +: DATA_WIDTH];
      assign w1_arr[g] = w1_all[g*DATA_WIDTH +: DATA_WIDTH];
      assign b_arr[g]  = b_all[g*DATA_WIDTH +: DATA_WIDTH];
      assign gates_out[g*DATA_WIDTH +: DATA_WIDTH] = gates_q[g];
   end

   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign mac_en    = (state_q == ISSUE);
   assign in_ready  = (state_q == IDLE) && !rst;

`ifdef LSTM_MAC_PIPE_EN
   // Results return one cycle after issue, so capture follows a delayed counter/enable.
   localparam state_e ISSUE_EXIT = DRAIN;
   logic             en_dly_q;
   logic [CNT_W-1:0] cnt_dly_q;

   // Delay line aligning the write slot with the registered shared-unit result
   always_ff @(posedge clk) begin
      if (rst) begin
         en_dly_q  <= 1'b0;
         cnt_dly_q <= '0;
      end else begin
         en_dly_q  <= mac_en;
         cnt_dly_q <= cnt_q;
      end
   end

   assign wr_en_s  = en_dly_q;
   assign wr_idx_s = cnt_dly_q;
`else
   localparam state_e ISSUE_EXIT = DONE;
   assign wr_en_s  = mac_en;
   assign wr_idx_s = cnt_q;
`endif

   // Operand steering onto the shared unit; forced to zero while idle
   always_comb begin
      mac_x  = '0;
      mac_h  = '0;
      mac_w0 = '0;
      mac_w1 = '0;
      mac_b  = '0;
      if (mac_en) begin
         mac_x  = x_q;
         mac_h  = h_q;
         mac_w0 = w0_arr[cnt_q];
         mac_w1 = w1_arr[cnt_q];
         mac_b  = b_arr[cnt_q];
      end else begin
         mac_x  = '0;
      end
   end

   // Next-state, counter and sample-capture logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      h_d     = h_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               x_d     = x;
               h_d     = h_in;
               cnt_d   = '0;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               state_d = ISSUE_EXIT;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         DRAIN: state_d = DONE;
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Result collection: the shared-unit output lands in the slot being retired
   always_comb begin
      gates_d = gates_q;
      if (wr_en_s) begin
         gates_d[wr_idx_s] = mac_out;
      end else begin
         gates_d = gates_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         h_q     <= '0;
         for (int g = 0; g < NUM_GATES; g++) begin
            gates_q[g] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         h_q     <= h_d;
         gates_q <= gates_d;
      end
   end

endmodule

// File: tb/tb_lstm_gate_scheduler.sv
// Scoreboard bench for lstm_gate_scheduler: stimulus posts hand-computed results, a monitor checks them.
module tb_lstm_gate_scheduler;

   localparam int DW = 16;
   localparam int NG = 4;
   localparam int FW = 8;
`ifdef LSTM_MAC_PIPE_EN
   localparam int LAT_EDGES = NG + 1;  // out_valid visible NG+1 edges after the accept edge (6 cycles)
   localparam int PERIOD    = NG + 3;
`else
   localparam int LAT_EDGES = NG;      // out_valid visible NG edges after the accept edge (5 cycles)
   localparam int PERIOD    = NG + 2;
`endif

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready, out_valid, out_ready, mac_en, busy;
   logic [DW-1:0] x_s, h_s, mac_x, mac_h, mac_w0, mac_w1, mac_b, mac_out, mac_comb;
   logic [NG*DW-1:0] w0_s, w1_s, b_s, gates_out, exp_cur;

   int n_chk = 0, n_fail = 0, n_out = 0, cyc = 0, to_cnt = 0, to_seen = 0;
   bit b2b = 1'b0, end_req = 1'b0;

   lstm_gate_scheduler #(.DATA_WIDTH(DW), .FRACT_WIDTH(FW), .NUM_GATES(NG)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x_s), .h_in(h_s),
      .w0_all(w0_s), .w1_all(w1_s), .b_all(b_s), .mac_en(mac_en), .mac_x(mac_x), .mac_h(mac_h),
      .mac_w0(mac_w0), .mac_w1(mac_w1), .mac_b(mac_b), .mac_out(mac_out), .out_valid(out_valid),
      .out_ready(out_ready), .gates_out(gates_out), .busy(busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Shared concat-multiply-add unit of the environment
   function automatic logic [DW-1:0] mac_f(input logic [DW-1:0] a, input logic [DW-1:0] h,
                                           input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                           input logic [DW-1:0] b);
      logic signed [31:0] p0, p1, s;
      p0 = $signed(w0) * $signed(a);
      p1 = $signed(w1) * $signed(h);
      s  = (p0 >>> FW) + (p1 >>> FW) + $signed({{(32-DW){b[DW-1]}}, b});
      return s[DW-1:0];
   endfunction

   assign mac_comb = mac_f(mac_x, mac_h, mac_w0, mac_w1, mac_b);
`ifdef LSTM_MAC_PIPE_EN
   logic [DW-1:0] mac_reg;
   always @(posedge clk) mac_reg <= rst ? '0 : mac_comb;
   assign mac_out = mac_reg;
`else
   assign mac_out = mac_comb;
`endif

   // ---------------- monitor / scoreboard ----------------
   logic [NG*DW-1:0] exp_q[$];
   int               acc_q[$];
   logic [NG*DW-1:0] held;
   logic [DW-1:0]    cap_x, cap_h;
   int  issue_idx = 0, last_acc = 0;
   bit  post_rst = 1'b0, prev_ov = 1'b0, hold_chk = 1'b0, pend_acc = 1'b0, have_prev = 1'b0;
   bit  end_done = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         acc_q.delete();
         chk("in_ready_during_rst", 64'(in_ready), 64'd0);
         post_rst = 1'b1; issue_idx = 0; prev_ov = 1'b0; hold_chk = 1'b0; pend_acc = 1'b0;
      end else begin
         if (post_rst) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_gates_out", 64'(gates_out), 64'd0);
            chk("rst_mac_en", 64'(mac_en), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            post_rst = 1'b0;
         end
         if (to_cnt != to_seen) begin
            chk("wait_bound_expired", 64'(to_cnt), 64'(to_seen));
            to_seen = to_cnt;
         end
         chk("in_ready_vs_busy", 64'(in_ready), 64'(!busy));
         if (pend_acc) chk("accept_1_after_out_ready", 64'(in_ready && in_valid), 64'd1);
         pend_acc = 1'b0;
         if (hold_chk) begin
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_gates_out", 64'(gates_out), 64'(held));
         end
         if (mac_en) begin
            chk("mac_x", 64'(mac_x), 64'(cap_x));
            chk("mac_h", 64'(mac_h), 64'(cap_h));
            chk("mac_w0", 64'(mac_w0), 64'(w0_s[issue_idx*DW +: DW]));
            chk("mac_w1", 64'(mac_w1), 64'(w1_s[issue_idx*DW +: DW]));
            chk("mac_b", 64'(mac_b), 64'(b_s[issue_idx*DW +: DW]));
            issue_idx++;
         end else begin
            chk("mac_zero_when_idle", 64'({mac_x, mac_h, mac_w0, mac_w1, mac_b} == '0), 64'd1);
         end
         if (out_valid && !prev_ov) begin
            if (acc_q.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
            else begin
               chk("latency_edges", 64'(cyc - acc_q.pop_front()), 64'(LAT_EDGES));
               chk("issue_count", 64'(issue_idx), 64'(NG));
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
            else chk("gates_out", 64'(gates_out), 64'(exp_q.pop_front()));
            n_out++;
            pend_acc = in_valid;
         end
         hold_chk = out_valid && !out_ready;
         held     = gates_out;
         if (in_valid && in_ready) begin
            exp_q.push_back(exp_cur);
            acc_q.push_back(cyc + 1);
            cap_x = x_s; cap_h = h_s; issue_idx = 0;
            if (b2b && have_prev) chk("b2b_period", 64'(cyc + 1 - last_acc), 64'(PERIOD));
            last_acc  = cyc + 1;
            have_prev = b2b;
         end
         prev_ov = out_valid;
         if (end_req && !end_done) begin
            chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
            end_done = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic offer(input logic [DW-1:0] xv, input logic [DW-1:0] hv, input logic [NG*DW-1:0] ev);
      x_s = xv; h_s = hv; exp_cur = ev; in_valid = 1'b1;
   endtask

   task automatic await_accept(input bit keep);
      bit ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (!ok) to_cnt++;
      @(posedge clk); #1;
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_outs(input int target);
      for (int n = 0; n < 300 && n_out < target; n++) @(posedge clk);
      if (n_out < target) to_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic basic_weights();
      w0_s = {4{16'h0100}};
      w1_s = {4{16'h0080}};
      b_s  = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      x_s = '0; h_s = '0; exp_cur = '0;
      basic_weights();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Basic transaction
      offer(16'h0100, 16'h0200, {16'h0500, 16'h0400, 16'h0300, 16'h0200});
      await_accept(1'b0);
      wait_outs(1);

      // Negative operand
      w0_s = {4{16'h0200}}; w1_s = '0; b_s = '0;
      offer(16'hFF00, 16'h1234, {4{16'hFE00}});
      await_accept(1'b0);
      wait_outs(2);

      // Backpressure with a second sample waiting
      w0_s = {16'hFF00, 16'h0080, 16'h0200, 16'h0100}; w1_s = {4{16'h0100}}; b_s = '0;
      out_ready = 1'b0;
      offer(16'h0300, 16'h0100, {16'hFE00, 16'h0280, 16'h0700, 16'h0400});
      await_accept(1'b0);
      for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
      if (!out_valid) to_cnt++;
      repeat (10) @(posedge clk);
      #1 offer(16'h0100, 16'h0100, {16'h0000, 16'h0180, 16'h0300, 16'h0200});
      @(posedge clk); #1 out_ready = 1'b1;
      await_accept(1'b0);
      wait_outs(4);

      // Reset while gate 2 is issued, then a clean transaction
      basic_weights();
      offer(16'h0100, 16'h0200, {16'h0500, 16'h0400, 16'h0300, 16'h0200});
      await_accept(1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      offer(16'h0100, 16'h0200, {16'h0500, 16'h0400, 16'h0300, 16'h0200});
      await_accept(1'b0);
      wait_outs(5);

      // Back-to-back samples with in_valid held high
      b2b = 1'b1;
      offer(16'h0200, 16'h0000, {16'h0500, 16'h0400, 16'h0300, 16'h0200});
      await_accept(1'b1);
      offer(16'h0000, 16'h0600, {16'h0600, 16'h0500, 16'h0400, 16'h0300});
      await_accept(1'b1);
      offer(16'hFE00, 16'h0000, {16'h0100, 16'h0000, 16'hFF00, 16'hFE00});
      await_accept(1'b0);
      wait_outs(8);
      b2b = 1'b0;

      end_req = 1'b1;
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lstm_gate_scheduler.md
Name: lstm_gate_scheduler

Overview:
Time-multiplexes one shared concat-multiply-add unit across the NUM_GATES LSTM gate pre-activations (input, forget, output, candidate). The shared unit computes ((W0*X)>>>FRACT_WIDTH) + ((W1*h_in)>>>FRACT_WIDTH) + b.
- Accepts one (x, h_in) sample per transaction through a valid/ready handshake.
- Steers the per-gate weights and bias onto the shared unit, one gate per cycle.
- Collects the results and presents all gate pre-activations together to the downstream activation stage.

Parameters:
DATA_WIDTH, 16, width of every signed fixed-point operand and result
FRACT_WIDTH, 8, fractional bits; informational, used by the bench reference model
NUM_GATES, 4, number of gates sequenced per transaction; gate g occupies bits [g*DATA_WIDTH +: DATA_WIDTH] of every flattened bus

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  x/h_in sample offered
in_ready  out  1  scheduler can accept a sample
x  in  DATA_WIDTH  input sample
h_in  in  DATA_WIDTH  previous hidden state
w0_all  in  NUM_GATES*DATA_WIDTH  per-gate X weights
w1_all  in  NUM_GATES*DATA_WIDTH  per-gate h weights
b_all  in  NUM_GATES*DATA_WIDTH  per-gate biases
mac_en  out  1  high while an operand set is driven to the shared unit
mac_x, mac_h, mac_w0, mac_w1, mac_b  out  DATA_WIDTH each  shared-unit operands
mac_out  in  DATA_WIDTH  shared-unit result
out_valid  out  1  gates_out holds a complete result set
out_ready  in  1  downstream accepts the result set
gates_out  out  NUM_GATES*DATA_WIDTH  gate pre-activations, gate g in slice g
busy  out  1  high in any state other than IDLE

Behaviour:
Reset (rst=1 at a clock edge), from any state, including mid-transaction:
- State goes to IDLE; gate counter = 0.
- out_valid = 0, busy = 0, mac_en = 0.
- gates_out = 0; x/h registers = 0.
- The transaction in flight is discarded; no partial output is produced.

Operand outputs:
- mac_* outputs are 0 whenever mac_en = 0.
- in_ready = 1 only in IDLE and only when rst = 0.

State IDLE:
- On in_valid & in_ready, capture x and h_in into registers; go to ISSUE with the counter = 0.

State ISSUE:
- mac_en = 1.
- mac_x = x_reg and mac_h = h_reg.
- mac_w0, mac_w1 and mac_b = slice[counter] of w0_all, w1_all and b_all, selected combinationally.
- The shared unit is combinational: each cycle, mac_out is written into gates_out slice[counter] at the clock edge.
- The counter increments each cycle. After the NUM_GATES-1 write, go to DONE.

State DONE:
- out_valid = 1; gates_out is held stable.
- On out_ready, clear out_valid and go to IDLE.
- gates_out keeps its last value until the next transaction overwrites it slice by slice.

Timing:
- Accept at edge T; gate g is issued in cycle T+1+g.
- out_valid rises after edge T+NUM_GATES, i.e. 5 cycles of latency for the default configuration.
- Minimum transaction period is NUM_GATES+2 cycles when out_ready is held high.

Weight inputs:
- w0_all, w1_all and b_all are not registered.
- The upstream must hold them stable from acceptance until out_valid.
- Changing them mid-ISSUE affects only gates issued after the change. This is legal and must not hang the scheduler.

Other rules:
- A new sample offered in DONE is not accepted; in_ready stays 0.
- The scheduler does no arithmetic on results: the value captured is exactly mac_out (full DATA_WIDTH, sign preserved).
- in_valid or out_ready asserted during reset is ignored.

Optional Feature:
LSTM_MAC_PIPE_EN:
- Defined: the shared unit has one output register stage. The scheduler captures mac_out one cycle after issue, using a delayed copy of the counter and mac_en.
- Defined: an extra DRAIN state follows ISSUE for one cycle, with mac_en = 0 and the capture of the last gate.
- Defined: latency becomes NUM_GATES+2 cycles (6 by default). Reset clears the delay registers.
- Undefined: the combinational capture timing described above.

Test Plan:
Basic transaction:
- Stimulus: x=0x0100, h_in=0x0200; all W0=0x0100, W1=0x0080; b_g = g*0x0100; shared unit modelled; out_ready=1.
- Required: out_valid 5 cycles after accept; gates_out slices = 0x0200, 0x0300, 0x0400, 0x0500; in_ready low for 6 cycles.

Negative operands:
- Stimulus: x=0xFF00, W0=0x0200, W1=0, b=0.
- Required: every slice = 0xFE00; mac_w0 = 0x0200 exactly during the four mac_en cycles.

Backpressure:
- Stimulus: hold out_ready=0 for 10 cycles after out_valid.
- Required: out_valid and gates_out stay stable; in_ready=0; a second in_valid is not accepted until 1 cycle after out_ready.

Reset mid-ISSUE:
- Stimulus: assert rst in the cycle gate 2 is issued.
- Required: next cycle state IDLE, out_valid=0, gates_out=0, mac_en=0, in_ready=1 after rst deasserts; a following transaction produces correct results.

Back-to-back:
- Stimulus: in_valid held high with 3 distinct samples; out_ready=1.
- Required: accepts exactly every 6 cycles; each result set matches the reference model in order.

Pipelined build:
- Stimulus: with LSTM_MAC_PIPE_EN defined and a registered shared-unit model, repeat the basic transaction.
- Required: latency 6; identical gates_out values.
